// File: rtl/axi_mem_responder.sv
// AXI4 slave memory responder: one INCR burst at a time, 128-bit beats, word-addressed RAM.
// Define AXI_MEM_RAND_STALL_EN to insert LFSR-driven WREADY / R-beat stalls.
module axi_mem_responder #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic [2:0]              S_AXI_AWSIZE,
    input  logic [1:0]              S_AXI_AWBURST,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic [2:0]              S_AXI_ARSIZE,
    input  logic [1:0]              S_AXI_ARBURST,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_RID,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t                 state_q, state_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [IDX_W-1:0]       idx_q, idx_d, idx_nxt;
    logic [8:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   awready_q, awready_d, arready_q, arready_d;
    logic                   wready_q, wready_d, bvalid_q, bvalid_d;
    logic                   rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   stall;
    logic                   aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic                   unused_sig;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

`ifdef AXI_MEM_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Size, burst type and sub-word address bits carry no meaning here.
    assign unused_sig = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWSIZE, S_AXI_AWBURST,
                          S_AXI_ARSIZE, S_AXI_ARBURST};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_ARREADY = arready_q & ~S_AXI_AWVALID;
    assign S_AXI_WREADY  = wready_q & ~stall;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = id_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RID     = id_q;
    assign S_AXI_RRESP   = 2'b00;

    assign aw_hs   = S_AXI_AWVALID & awready_q;
    assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
    assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
    assign b_hs    = bvalid_q & S_AXI_BREADY;
    assign r_hs    = rvalid_q & S_AXI_RREADY;
    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    id_d    = S_AXI_AWID;
                    idx_d   = S_AXI_AWADDR[IDX_W+3:4];
                    cnt_d   = {1'b0, S_AXI_AWLEN} + 9'd1;
                    err_d   = 1'b0;
                    state_d = WDATA;
                end else if (ar_hs) begin
                    id_d     = S_AXI_ARID;
                    idx_d    = S_AXI_ARADDR[IDX_W+3:4];
                    cnt_d    = {1'b0, S_AXI_ARLEN} + 9'd1;
                    rdata_d  = mem[S_AXI_ARADDR[IDX_W+3:4]];
                    rlast_d  = (S_AXI_ARLEN == 8'd0);
                    rvalid_d = 1'b1;
                    state_d  = RDATA;
                end
            end
            WDATA: begin
                if (w_hs) begin
                    idx_d = idx_nxt;
                    cnt_d = cnt_q - 9'd1;
                    // The beat count ends the burst; a misplaced WLAST only flags an error.
                    if (S_AXI_WLAST != (cnt_q == 9'd1)) err_d = 1'b1;
                    if (cnt_q == 9'd1) begin
                        state_d  = WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = {err_d, 1'b0};
                    end
                end
            end
            WRESP: begin
                if (b_hs) begin
                    bvalid_d = 1'b0;
                    bresp_d  = 2'b00;
                    state_d  = IDLE;
                end
            end
            RDATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        idx_d    = idx_nxt;
                        cnt_d    = cnt_q - 9'd1;
                        rdata_d  = mem[idx_nxt];
                        rlast_d  = (cnt_q == 9'd2);
                        rvalid_d = ~stall;
                    end
                end else if (!rvalid_q && !stall) begin
                    rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        awready_d = (state_d == IDLE);
        arready_d = (state_d == IDLE);
        wready_d  = (state_d == WDATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_hs) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) mem[idx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed scoreboard bench for axi_mem_responder (default build, DEPTH=4096).
module tb_axi_mem_responder;
    localparam int IDW   = 1;
    localparam int AW    = 27;
    localparam int DW    = 128;
    localparam int DEPTH = 4096;
    localparam int LIM   = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [IDW-1:0]  awid, arid, bid, rid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;

    axi_mem_responder dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] model [int];
    logic [DW-1:0] wq [$];
    logic [DW-1:0] rq [$];
    logic [2:0]    bq [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, DW'({awready, wready, bvalid, arready, rvalid, rlast,
                                 bresp, rresp, bid, rid}), '0);
        chk({tag, "_rdata"}, rdata, '0);
    endtask

    // Drives one write burst from wq; abort_at >= 0 asserts rst after that beat.
    task automatic do_write(input int id, input int addr, input int len,
                            input logic [DW/8-1:0] strb, input bit bad_wlast, input int abort_at);
        int n;
        int idx;
        logic [DW-1:0] d, w;
        logic [2:0] e;
        idx = (addr >> 4) % DEPTH;
        if (abort_at < 0) bq.push_back({IDW'(id), bad_wlast ? 2'b10 : 2'b00});
        awid = IDW'(id); awaddr = AW'(addr); awlen = 8'(len);
        awsize = 3'd4; awburst = 2'b01; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < LIM) begin tick(); #1; n++; end
        chk("aw_wait", DW'(n < LIM), DW'(1));
        tick();
        awvalid = 1'b0;
        chk("wready_t1", DW'(wready), DW'(1));
        for (int b = 0; b <= len; b++) begin
            d = wq.pop_front();
            wvalid = 1'b1; wdata = d; wstrb = strb;
            wlast = bad_wlast ? (b == 0) : (b == len);
            n = 0;
            while (!wready && n < LIM) begin tick(); n++; end
            chk("w_wait", DW'(n < LIM), DW'(1));
            w = model.exists(idx) ? model[idx] : '0;
            for (int k = 0; k < DW/8; k++) if (strb[k]) w[8*k +: 8] = d[8*k +: 8];
            model[idx] = w;
            idx = (idx + 1) % DEPTH;
            tick();
            if (b == abort_at) begin
                wvalid = 1'b0; wlast = 1'b0; rst = 1'b1;
                tick();
                chk_reset_outputs("rst_mid_write");
                rst = 1'b0;
                wq.delete();
                return;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_t1", DW'(bvalid), DW'(1));
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < LIM) begin tick(); n++; end
        e = bq.pop_front();
        chk("bid", DW'(bid), DW'(e[2]));
        chk("bresp", DW'(bresp), DW'(e[1:0]));
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input int id, input int addr, input int len, input bit bp);
        int n;
        int idx;
        logic [DW-1:0] e;
        idx = (addr >> 4) % DEPTH;
        for (int b = 0; b <= len; b++) rq.push_back(model[(idx + b) % DEPTH]);
        arid = IDW'(id); araddr = AW'(addr); arlen = 8'(len);
        arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < LIM) begin tick(); #1; n++; end
        chk("ar_wait", DW'(n < LIM), DW'(1));
        tick();
        arvalid = 1'b0;
        chk("rvalid_t1", DW'(rvalid), DW'(1));
        rready = 1'b1;
        for (int b = 0; b <= len; b++) begin
            n = 0;
            while (!rvalid && n < LIM) begin tick(); n++; end
            chk("r_wait", DW'(n < LIM), DW'(1));
            e = rq.pop_front();
            chk("rdata", rdata, e);
            chk("rlast", DW'(rlast), DW'(b == len));
            chk("rid", DW'(rid), DW'(id));
            if (bp && b == 1) begin
                rready = 1'b0;
                repeat (3) begin
                    tick();
                    chk("bp_rvalid", DW'(rvalid), DW'(1));
                    chk("bp_rdata", rdata, e);
                    chk("bp_rlast", DW'(rlast), DW'(b == len));
                end
                rready = 1'b1;
            end
            tick();
        end
        rready = 1'b0;
        chk("arready_again", DW'(arready), DW'(1));
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic burst write then read back, second read with backpressure
        for (int i = 0; i < 4; i++) wq.push_back(DW'(i * 32'h1111));
        do_write(1, 'h40, 3, '1, 1'b0, -1);
        do_read(0, 'h40, 3, 1'b0);
        do_read(1, 'h40, 3, 1'b1);

        // Byte strobes over an all-ones word
        wq.push_back('1);
        do_write(0, 'h100, 0, '1, 1'b0, -1);
        wq.push_back('0);
        do_write(0, 'h100, 0, 16'h00FF, 1'b0, -1);
        chk("strobe_model", model[16], {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        do_read(1, 'h100, 0, 1'b0);

        // Simultaneous AW/AR: the write wins and the read sees its data
        arid = 1'b1; araddr = AW'('h200); arlen = 8'd0; arvalid = 1'b1;
        awaddr = AW'('h200); awvalid = 1'b1;
        #1;
        chk("sim_arready", DW'(arready), DW'(0));
        chk("sim_awready", DW'(awready), DW'(1));
        wq.push_back({32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF});
        do_write(0, 'h200, 0, '1, 1'b0, -1);
        do_read(1, 'h200, 0, 1'b0);

        // Wrap from the last word to word 0 with WLAST on beat 0
        wq.push_back({4{32'hA5A5A5A5}});
        wq.push_back({4{32'h5A5A5A5A}});
        do_write(1, 'hFFF0, 1, '1, 1'b1, -1);
        do_read(0, 'hFFF0, 1, 1'b0);

        // Reset mid-burst, then a fresh write on the same region
        for (int i = 0; i < 4; i++) wq.push_back(DW'(32'h7700 + i));
        do_write(0, 'h300, 3, '1, 1'b0, 1);
        wq.push_back(DW'(64'h1122334455667788));
        do_write(1, 'h300, 0, '1, 1'b0, -1);
        do_read(0, 'h300, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
